// File: rtl/pump_session_ctrl.sv
// pump_session_ctrl: sequences one fuelling session (arm, pump, pause, done) around the pump
// datapath, counting flow-meter pulses up to a target latched when the session starts.
`timescale 1ns/1ps
module pump_session_ctrl #(
    parameter int WIDTH         = 24,
    parameter int ARM_TIMEOUT   = 1000,
    parameter int PAUSE_TIMEOUT = 500
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] target_lit,
    input  logic             valve,
    input  logic             flow_pulse,
    input  logic             cancel,
    output logic [2:0]       gas,
    output logic [WIDTH-1:0] dispensed,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       state
);
    localparam int TMAX = (ARM_TIMEOUT > PAUSE_TIMEOUT) ? ARM_TIMEOUT : PAUSE_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_PUMP  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_n;
    logic [TW-1:0]    timer_q, timer_n;
    logic [WIDTH-1:0] disp_q, disp_n;
    logic [WIDTH-1:0] tgt_q, tgt_n;
    logic [2:0]       sel_q, sel_n;
    logic             start_q;
    logic             err_q, err_n;

    logic start_rise;
    logic flow_hits_target;
    logic arm_expired;
    logic pause_expired;

    assign start_rise       = start & ~start_q;
    assign flow_hits_target = flow_pulse && ((disp_q + WIDTH'(1)) == tgt_q);
    // A timer value of TIMEOUT-1 on an edge means the state has lasted TIMEOUT cycles.
    assign arm_expired      = timer_q >= TW'(ARM_TIMEOUT - 1);
    assign pause_expired    = timer_q >= TW'(PAUSE_TIMEOUT - 1);

    always_comb begin
        // NOTE: every next-value variable is defaulted first so no branch can infer a latch.
        state_n = state_q;
        disp_n  = disp_q;
        tgt_n   = tgt_q;
        sel_n   = sel_q;
        err_n   = 1'b0;
        timer_n = (timer_q == '1) ? timer_q : timer_q + TW'(1);

        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    if ($onehot(select) && (target_lit != '0)) begin
                        state_n = S_ARMED;
                        sel_n   = select;
                        tgt_n   = target_lit;
                        disp_n  = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (cancel)           state_n = S_DONE;
                else if (valve)       state_n = S_PUMP;
                else if (arm_expired) state_n = S_IDLE;
            end
            S_PUMP: begin
                if (cancel) begin
                    state_n = S_DONE;
                end else if (flow_hits_target) begin
                    disp_n  = tgt_q;
                    state_n = S_DONE;
                end else begin
                    if (flow_pulse) disp_n = disp_q + WIDTH'(1);
                    if (!valve)     state_n = S_PAUSE;
                end
            end
            S_PAUSE: begin
                // Meter drip while the nozzle is closed still counts toward the target.
                if (cancel) begin
                    state_n = S_DONE;
                end else if (flow_hits_target) begin
                    disp_n  = tgt_q;
                    state_n = S_DONE;
                end else begin
                    if (flow_pulse)         disp_n = disp_q + WIDTH'(1);
                    if (valve)              state_n = S_PUMP;
                    else if (pause_expired) state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        if (state_n != state_q) timer_n = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            disp_q  <= '0;
            tgt_q   <= '0;
            sel_q   <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q <= state_n;
            timer_q <= timer_n;
            disp_q  <= disp_n;
            tgt_q   <= tgt_n;
            sel_q   <= sel_n;
            start_q <= start;
            err_q   <= err_n;
        end
    end

    // All outputs decode registered state only, so gas drops the moment reset asserts.
    assign state     = state_q;
    assign gas       = (state_q == S_PUMP) ? sel_q : 3'b000;
    assign busy      = state_q inside {S_ARMED, S_PUMP, S_PAUSE};
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign dispensed = disp_q;

endmodule

// File: tb/tb_pump_session_ctrl.sv
// tb_pump_session_ctrl: directed session scenarios plus randomized traffic, checked every cycle
// against a session-level behavioural model of the pump controller.
`timescale 1ns/1ps
module tb_pump_session_ctrl;
    localparam int WIDTH   = 8;
    localparam int ARM_T   = 8;
    localparam int PAUSE_T = 12;

    localparam int PH_IDLE  = 0;
    localparam int PH_ARMED = 1;
    localparam int PH_PUMP  = 2;
    localparam int PH_PAUSE = 3;
    localparam int PH_DONE  = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       select = 3'b000;
    logic [WIDTH-1:0] target_lit = '0;
    logic             valve = 1'b0;
    logic             flow_pulse = 1'b0;
    logic             cancel = 1'b0;
    logic [2:0]       gas;
    logic [WIDTH-1:0] dispensed;
    logic             busy;
    logic             done;
    logic             err;
    logic [2:0]       dut_state;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    pump_session_ctrl #(
        .WIDTH(WIDTH), .ARM_TIMEOUT(ARM_T), .PAUSE_TIMEOUT(PAUSE_T)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .select(select), .target_lit(target_lit),
        .valve(valve), .flow_pulse(flow_pulse), .cancel(cancel), .gas(gas),
        .dispensed(dispensed), .busy(busy), .done(done), .err(err), .state(dut_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int ph;          // session phase, numbered as the debug state code
        int disp;        // units delivered this session
        int tgt;         // units requested
        int sel;         // fuel selected at start
        int waited;      // cycles spent in the current waiting phase
        bit err;
        bit start_prev;
    } model_t;

    model_t mdl = '0;

    function automatic model_t model_next(model_t m, logic st, logic [2:0] sel,
                                          logic [WIDTH-1:0] tgt, logic vlv, logic flow,
                                          logic cncl);
        model_t n = m;
        bit rise  = st && !m.start_prev;
        n.err        = 1'b0;
        n.start_prev = st;
        case (m.ph)
            PH_IDLE: if (rise) begin
                if ($countones(sel) == 1 && tgt != 0) begin
                    n.ph = PH_ARMED; n.sel = int'(sel); n.tgt = int'(tgt);
                    n.disp = 0; n.waited = 0;
                end else begin
                    n.err = 1'b1;
                end
            end
            PH_ARMED: begin
                n.waited = m.waited + 1;
                if (cncl)                  n.ph = PH_DONE;
                else if (vlv)              n.ph = PH_PUMP;
                else if (n.waited == ARM_T) n.ph = PH_IDLE;
            end
            PH_PUMP: if (cncl) n.ph = PH_DONE;
            else begin
                if (flow) n.disp = m.disp + 1;
                if (n.disp == m.tgt) n.ph = PH_DONE;
                else if (!vlv) begin n.ph = PH_PAUSE; n.waited = 0; end
            end
            PH_PAUSE: begin
                n.waited = m.waited + 1;
                if (cncl) n.ph = PH_DONE;
                else begin
                    if (flow) n.disp = m.disp + 1;
                    if (n.disp == m.tgt)          n.ph = PH_DONE;
                    else if (vlv)                 n.ph = PH_PUMP;
                    else if (n.waited == PAUSE_T) n.ph = PH_DONE;
                end
            end
            default: n.ph = PH_IDLE;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) mdl <= '0;
        else        mdl <= model_next(mdl, start, select, target_lit, valve, flow_pulse, cancel);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("state",     32'(dut_state), 32'(mdl.ph));
            check("gas",       32'(gas), (mdl.ph == PH_PUMP) ? 32'(mdl.sel) : 32'd0);
            check("dispensed", 32'(dispensed), 32'(mdl.disp));
            check("busy",      32'(busy), 32'(mdl.ph >= PH_ARMED && mdl.ph <= PH_PAUSE));
            check("done",      32'(done), 32'(mdl.ph == PH_DONE));
            check("err",       32'(err), 32'(mdl.err));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic start_session(input logic [2:0] s, input logic [WIDTH-1:0] t);
        select = s; target_lit = t; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) begin
            flow_pulse = 1'b1; step();
            flow_pulse = 1'b0; step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        check("rst_state", 32'(dut_state), 32'd0);
        check("rst_gas",   32'(gas), 32'd0);
        check("rst_disp",  32'(dispensed), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        #10 reset = 1'b1;
        step();
        chk_en = 1'b1;

        // Full session to target 5
        start_session(3'b001, 8'd5);
        check("t2_armed", 32'(dut_state), 32'd1);
        valve = 1'b1; step();
        check("t2_gas", 32'(gas), 32'b001);
        pulses(4);
        check("t2_disp4", 32'(dispensed), 32'd4);
        flow_pulse = 1'b1; step(); flow_pulse = 1'b0;
        check("t2_done",  32'(done), 32'd1);
        check("t2_gas0",  32'(gas), 32'd0);
        check("t2_disp5", 32'(dispensed), 32'd5);
        check("t2_model_disp", 32'(mdl.disp), 32'd5);
        valve = 1'b0; step();

        // Rejected starts
        start_session(3'b011, 8'd5);
        check("t3_err_sel", 32'(err), 32'd1);
        check("t3_state",   32'(dut_state), 32'd0);
        step();
        check("t3_err_clr", 32'(err), 32'd0);
        start_session(3'b001, 8'd0);
        check("t3_err_tgt", 32'(err), 32'd1);
        check("t3_gas",     32'(gas), 32'd0);
        step();

        // Arm timeout
        start_session(3'b100, 8'd7);
        repeat (ARM_T - 1) step();
        check("t4_still_armed", 32'(dut_state), 32'd1);
        step();
        check("t4_idle", 32'(dut_state), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_done", 32'(done), 32'd0);

        // Pause with drip, then resume to target 10
        start_session(3'b100, 8'd10);
        valve = 1'b1; step();
        pulses(4);
        valve = 1'b0; step();
        check("t5_pause", 32'(dut_state), 32'd3);
        flow_pulse = 1'b1; step(); flow_pulse = 1'b0;
        check("t5_drip", 32'(dispensed), 32'd5);
        valve = 1'b1; step();
        pulses(4);
        flow_pulse = 1'b1; step(); flow_pulse = 1'b0;
        check("t5_disp10", 32'(dispensed), 32'd10);
        check("t5_done",   32'(done), 32'd1);
        valve = 1'b0; step();

        // Pause timeout
        start_session(3'b100, 8'd10);
        valve = 1'b1; step();
        pulses(5);
        valve = 1'b0; step();
        repeat (PAUSE_T - 1) step();
        check("t5b_pause", 32'(dut_state), 32'd3);
        step();
        check("t5b_done", 32'(done), 32'd1);
        check("t5b_disp", 32'(dispensed), 32'd5);
        check("t5b_model_ph", 32'(mdl.ph), 32'd4);
        step();

        // Cancel beats the final pulse
        start_session(3'b010, 8'd3);
        valve = 1'b1; step();
        pulses(2);
        cancel = 1'b1; flow_pulse = 1'b1; step();
        cancel = 1'b0; flow_pulse = 1'b0;
        check("t6_done", 32'(done), 32'd1);
        check("t6_disp", 32'(dispensed), 32'd2);
        valve = 1'b0; step();

        // Start re-rise while busy is ignored
        start_session(3'b001, 8'd4);
        start = 1'b1; step();
        check("t6_rerise_err", 32'(err), 32'd0);
        start = 1'b0; valve = 1'b1; step();
        start = 1'b1; step();
        check("t6_rerise_pump", 32'(dut_state), 32'd2);
        start = 1'b0; cancel = 1'b1; step();
        cancel = 1'b0; valve = 1'b0; step();

        // Cancel while armed
        start_session(3'b001, 8'd4);
        cancel = 1'b1; step(); cancel = 1'b0;
        check("t6_armcancel_done", 32'(done), 32'd1);
        check("t6_armcancel_disp", 32'(dispensed), 32'd0);
        step();

        // Async reset mid-pump
        start_session(3'b010, 8'd20);
        valve = 1'b1; step();
        pulses(3);
        check("t1_gas_pump", 32'(gas), 32'b010);
        chk_en = 1'b0;
        #3 reset = 1'b0;
        #1;
        check("t1_gas",   32'(gas), 32'd0);
        check("t1_state", 32'(dut_state), 32'd0);
        check("t1_disp",  32'(dispensed), 32'd0);
        valve = 1'b0;
        step();
        #3 reset = 1'b1;
        step();
        chk_en = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) start = ~start;
            if ($urandom_range(0, 3) == 0) begin
                select     = ($urandom_range(0, 4) == 0) ? 3'($urandom)
                                                         : (3'b001 << $urandom_range(0, 2));
                target_lit = WIDTH'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 9) == 0) valve = ~valve;
            flow_pulse = ($urandom_range(0, 2) == 0);
            cancel     = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
